// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath sizes, opcodes
// and the operand-stage occupancy states.
package alu_pkg;

  localparam int WIDTH      = 32;
  localparam int OP_W       = 4;
  localparam int REG_ADDR_W = 5;

  // Opcodes shared with the ALU decode
  typedef enum logic [OP_W-1:0] {
    ALU_AND  = 4'd0,
    ALU_OR   = 4'd1,
    ALU_XOR  = 4'd2,
    ALU_NOR  = 4'd3,
    ALU_ADD  = 4'd4,
    ALU_SUB  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  // Operand stage holds at most one instruction
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_e;

endpackage

// File: rtl/alu_operand_stage_fwd_mux.sv
// Per-source bypass select: EX result beats WB result,
// register 0 is never bypassed.
module fwd_mux #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [WIDTH-1:0]  rf_data,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [WIDTH-1:0]  ex_data,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [WIDTH-1:0]  wb_data,
  output logic [WIDTH-1:0]  sel_data
);

  logic src_nz;
  logic ex_hit;
  logic wb_hit;

  assign src_nz = |src_addr;
  assign ex_hit = src_nz && ex_valid
               && (ex_addr == src_addr);
  assign wb_hit = src_nz && wb_valid
               && (wb_addr == src_addr)
               && !ex_hit;

  // One-hot select of bypass or register data
  always_comb begin
    sel_data = rf_data;
    unique case (1'b1)
      ex_hit:  sel_data = ex_data;
      wb_hit:  sel_data = wb_data;
      default: sel_data = rf_data;
    endcase
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Decode-to-ALU pipeline register with operand
// forwarding, immediate select and valid/ready flow.
module alu_operand_stage #(
  parameter int WIDTH = 32,
  parameter int IMM_W = 16,
  parameter int OP_W  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [alu_pkg::REG_ADDR_W-1:0] RsAddr,
  input  logic [alu_pkg::REG_ADDR_W-1:0] RtAddr,
  input  logic [WIDTH-1:0]              RsData,
  input  logic [WIDTH-1:0]              RtData,
  input  logic [IMM_W-1:0]              Imm,
  input  logic                          ImmSel,
  input  logic                          ImmSigned,
  input  logic [OP_W-1:0]               AluOp,
  input  logic [alu_pkg::REG_ADDR_W-1:0] DestAddr,
  input  logic                          ExFwdValid,
  input  logic [alu_pkg::REG_ADDR_W-1:0] ExFwdAddr,
  input  logic [WIDTH-1:0]              ExFwdData,
  input  logic                          WbFwdValid,
  input  logic [alu_pkg::REG_ADDR_W-1:0] WbFwdAddr,
  input  logic [WIDTH-1:0]              WbFwdData,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              A,
  output logic [WIDTH-1:0]              B,
  output logic [OP_W-1:0]               OpOut,
  output logic [alu_pkg::REG_ADDR_W-1:0] DestOut
);

  import alu_pkg::*;

  stage_state_e state;

  logic             capture;
  logic [WIDTH-1:0] rs_fwd;
  logic [WIDTH-1:0] rt_fwd;
  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] b_sel;
  logic             imm_fill;

  fwd_mux #(
    .WIDTH  (WIDTH),
    .ADDR_W (REG_ADDR_W)
  ) u_rs_fwd (
    .src_addr (RsAddr),
    .rf_data  (RsData),
    .ex_valid (ExFwdValid),
    .ex_addr  (ExFwdAddr),
    .ex_data  (ExFwdData),
    .wb_valid (WbFwdValid),
    .wb_addr  (WbFwdAddr),
    .wb_data  (WbFwdData),
    .sel_data (rs_fwd)
  );

  fwd_mux #(
    .WIDTH  (WIDTH),
    .ADDR_W (REG_ADDR_W)
  ) u_rt_fwd (
    .src_addr (RtAddr),
    .rf_data  (RtData),
    .ex_valid (ExFwdValid),
    .ex_addr  (ExFwdAddr),
    .ex_data  (ExFwdData),
    .wb_valid (WbFwdValid),
    .wb_addr  (WbFwdAddr),
    .wb_data  (WbFwdData),
    .sel_data (rt_fwd)
  );

  assign out_valid = (state == ST_FULL);

  // Ready never looks at in_valid
  assign in_ready = !flush
                 && (!out_valid || out_ready);
  assign capture  = in_valid && in_ready;

  assign imm_fill = ImmSigned && Imm[IMM_W-1];
  assign imm_ext  = {{(WIDTH-IMM_W){imm_fill}}, Imm};
  assign b_sel    = ImmSel ? imm_ext : rt_fwd;

  // Occupancy FSM and operand registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_EMPTY;
      A       <= '0;
      B       <= '0;
      OpOut   <= '0;
      DestOut <= '0;
    end else if (flush) begin
      state <= ST_EMPTY;
    end else if (capture) begin
      state   <= ST_FULL;
      A       <= rs_fwd;
      B       <= b_sel;
      OpOut   <= AluOp;
      DestOut <= DestAddr;
    end else if (out_ready) begin
      state <= ST_EMPTY;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: expected
// operands queued at capture, compared at output.
module tb_alu_operand_stage;

  import alu_pkg::*;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  dest;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  RsAddr = '0;
  logic [4:0]  RtAddr = '0;
  logic [31:0] RsData = '0;
  logic [31:0] RtData = '0;
  logic [15:0] Imm = '0;
  logic        ImmSel = 1'b0;
  logic        ImmSigned = 1'b0;
  logic [3:0]  AluOp = '0;
  logic [4:0]  DestAddr = '0;
  logic        ExFwdValid = 1'b0;
  logic [4:0]  ExFwdAddr = '0;
  logic [31:0] ExFwdData = '0;
  logic        WbFwdValid = 1'b0;
  logic [4:0]  WbFwdAddr = '0;
  logic [31:0] WbFwdData = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  OpOut;
  logic [4:0]  DestOut;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  logic mv = 1'b0;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .RsAddr     (RsAddr),
    .RtAddr     (RtAddr),
    .RsData     (RsData),
    .RtData     (RtData),
    .Imm        (Imm),
    .ImmSel     (ImmSel),
    .ImmSigned  (ImmSigned),
    .AluOp      (AluOp),
    .DestAddr   (DestAddr),
    .ExFwdValid (ExFwdValid),
    .ExFwdAddr  (ExFwdAddr),
    .ExFwdData  (ExFwdData),
    .WbFwdValid (WbFwdValid),
    .WbFwdAddr  (WbFwdAddr),
    .WbFwdData  (WbFwdData),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .A          (A),
    .B          (B),
    .OpOut      (OpOut),
    .DestOut    (DestOut)
  );

  function automatic logic [31:0] fwd(
    input logic [4:0]  addr,
    input logic [31:0] rf
  );
    if (addr == 5'd0) return rf;
    if (ExFwdValid && ExFwdAddr == addr)
      return ExFwdData;
    if (WbFwdValid && WbFwdAddr == addr)
      return WbFwdData;
    return rf;
  endfunction

  function automatic exp_t model();
    exp_t e;
    e.a = fwd(RsAddr, RsData);
    if (ImmSel)
      e.b = ImmSigned ? {{16{Imm[15]}}, Imm}
                      : {16'h0, Imm};
    else
      e.b = fwd(RtAddr, RtData);
    e.op   = AluOp;
    e.dest = DestAddr;
    return e;
  endfunction

  // Advance one clock and update the reference model
  task automatic tick();
    logic cap;
    cap = rst_n && in_valid && !flush
       && (!mv || out_ready);
    if (!rst_n) begin
      q.delete();
      mv = 1'b0;
    end else begin
      if (mv && (flush || out_ready))
        void'(q.pop_front());
      if (cap) q.push_back(model());
      if (flush)          mv = 1'b0;
      else if (cap)       mv = 1'b1;
      else if (out_ready) mv = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(
    input logic [4:0]  rs,
    input logic [31:0] rsd,
    input logic [4:0]  rt,
    input logic [31:0] rtd,
    input logic [15:0] imm,
    input logic        isel,
    input logic        isgn,
    input logic [3:0]  op,
    input logic [4:0]  dest
  );
    RsAddr = rs;   RsData = rsd;
    RtAddr = rt;   RtData = rtd;
    Imm = imm;     ImmSel = isel;
    ImmSigned = isgn;
    AluOp = op;    DestAddr = dest;
  endtask

  task automatic set_fwd(
    input logic        exv,
    input logic [4:0]  exa,
    input logic [31:0] exd,
    input logic        wbv,
    input logic [4:0]  wba,
    input logic [31:0] wbd
  );
    ExFwdValid = exv; ExFwdAddr = exa;
    ExFwdData = exd;
    WbFwdValid = wbv; WbFwdAddr = wba;
    WbFwdData = wbd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    set_instr(5'd9, 32'h1234_5678, 5'd8,
              32'h9ABC_DEF0, 16'h0, 1'b0, 1'b0,
              4'd4, 5'd3);
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || A !== 32'h0
        || B !== 32'h0 || OpOut !== 4'h0
        || DestOut !== 5'h0) begin
      errors++;
      $display("FAIL reset: v=%b A=%h B=%h op=%h d=%h, need all 0",
               out_valid, A, B, OpOut, DestOut);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b need 1",
               in_ready);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_capture();
    out_ready = 1'b1;
    in_valid = 1'b1;
    set_instr(5'd3, 32'h0000_00F0, 5'd4,
              32'h0000_0F0F, 16'h0, 1'b0, 1'b0,
              ALU_AND, 5'd7);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || A !== 32'h0000_00F0
        || B !== 32'h0000_0F0F
        || {A, B, OpOut, DestOut} !== q[0]) begin
      errors++;
      $display("FAIL capture: v=%b A=%h B=%h op=%h d=%h need A=000000f0 B=00000f0f",
               out_valid, A, B, OpOut, DestOut);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL consume: out_valid=%b need 0",
               out_valid);
    end
  endtask

  task automatic test_forward();
    out_ready = 1'b1;
    in_valid = 1'b1;
    set_instr(5'd5, 32'h1111_1111, 5'd5,
              32'h2222_2222, 16'h0, 1'b0, 1'b0,
              ALU_ADD, 5'd1);
    set_fwd(1'b1, 5'd5, 32'hAAAA_AAAA,
            1'b1, 5'd5, 32'h5555_5555);
    tick();
    checks++;
    if (out_valid !== 1'b1 || A !== 32'hAAAA_AAAA
        || {A, B, OpOut, DestOut} !== q[0]) begin
      errors++;
      $display("FAIL fwd_ex_prio: A=%h B=%h need A=aaaaaaaa exp=%h",
               A, B, q[0]);
    end
    set_instr(5'd6, 32'h1111_1111, 5'd7,
              32'h3333_3333, 16'h0, 1'b0, 1'b0,
              ALU_SUB, 5'd2);
    set_fwd(1'b1, 5'd7, 32'hCCCC_0000,
            1'b1, 5'd6, 32'h0000_DDDD);
    tick();
    checks++;
    if (A !== 32'h0000_DDDD || B !== 32'hCCCC_0000
        || {A, B, OpOut, DestOut} !== q[0]) begin
      errors++;
      $display("FAIL fwd_wb: A=%h B=%h need A=0000dddd B=cccc0000",
               A, B);
    end
    set_instr(5'd0, 32'h0BAD_F00D, 5'd0,
              32'h0000_0000, 16'h0, 1'b0, 1'b0,
              ALU_OR, 5'd3);
    set_fwd(1'b1, 5'd0, 32'hAAAA_AAAA,
            1'b1, 5'd0, 32'h5555_5555);
    tick();
    checks++;
    if (A !== 32'h0BAD_F00D || B !== 32'h0
        || {A, B, OpOut, DestOut} !== q[0]) begin
      errors++;
      $display("FAIL fwd_r0: A=%h B=%h need A=0badf00d B=0",
               A, B);
    end
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_imm();
    out_ready = 1'b1;
    in_valid = 1'b1;
    set_instr(5'd1, 32'h10, 5'd2, 32'h20,
              16'h8001, 1'b1, 1'b1, ALU_ADD, 5'd4);
    tick();
    checks++;
    if (B !== 32'hFFFF_8001
        || {A, B, OpOut, DestOut} !== q[0]) begin
      errors++;
      $display("FAIL imm_signed: B=%h need ffff8001",
               B);
    end
    ImmSigned = 1'b0;
    tick();
    checks++;
    if (B !== 32'h0000_8001
        || {A, B, OpOut, DestOut} !== q[0]) begin
      errors++;
      $display("FAIL imm_zero: B=%h need 00008001",
               B);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    out_ready = 1'b1;
    in_valid = 1'b1;
    set_instr(5'd8, 32'h0808_0808, 5'd9,
              32'h0909_0909, 16'h0, 1'b0, 1'b0,
              ALU_XOR, 5'd10);
    tick();
    for (int i = 0; i < 3; i++) begin
      out_ready = 1'b0;
      set_instr(5'd8, 32'h100 + i, 5'd9,
                32'h200 + i, 16'h0, 1'b0, 1'b0,
                ALU_SLT, 5'd11);
      set_fwd(1'b1, 5'd8, 32'hE000 + i,
              1'b1, 5'd9, 32'hB000 + i);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_ready[%0d]: got %b need 0",
                 i, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || A !== 32'h0808_0808
          || B !== 32'h0909_0909
          || {A, B, OpOut, DestOut} !== q[0]) begin
        errors++;
        $display("FAIL stall_hold[%0d]: v=%b A=%h B=%h need 08080808/09090909",
                 i, out_valid, A, B);
      end
    end
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    set_instr(5'd12, 32'h0C0C_0C0C, 5'd13,
              32'h0D0D_0D0D, 16'h0, 1'b0, 1'b0,
              ALU_OR, 5'd14);
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: in_ready=%b need 1",
               in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || A !== 32'h0C0C_0C0C
        || {A, B, OpOut, DestOut} !== q[0]) begin
      errors++;
      $display("FAIL stall_next: v=%b A=%h need 0c0c0c0c",
               out_valid, A);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    in_valid = 1'b1;
    set_instr(5'd15, 32'hF00F_F00F, 5'd16,
              32'h1, 16'h0, 1'b0, 1'b0,
              ALU_ADD, 5'd17);
    tick();
    out_ready = 1'b0;
    set_instr(5'd18, 32'h1818_1818, 5'd19,
              32'h2, 16'h0, 1'b0, 1'b0,
              ALU_SUB, 5'd20);
    flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: got %b need 0",
               in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_full: out_valid=%b need 0",
               out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_empty: out_valid=%b need 0",
               out_valid);
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      set_instr(5'd21, 32'h100 + i, 5'd22,
                32'h200 + i, 16'h0, 1'b0, 1'b0,
                ALU_ADD, 5'(i + 1));
      tick();
      checks++;
      if (out_valid !== 1'b1 || A !== 32'h100 + i
          || {A, B, OpOut, DestOut} !== q[0]) begin
        errors++;
        $display("FAIL b2b[%0d]: v=%b A=%h d=%h need A=%h",
                 i, out_valid, A, DestOut,
                 32'h100 + i);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b1;
    in_valid = 1'b1;
    set_instr(5'd23, 32'h2323_2323, 5'd24,
              32'h3, 16'h0, 1'b0, 1'b0,
              ALU_AND, 5'd25);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || A !== 32'h0
        || DestOut !== 5'h0) begin
      errors++;
      $display("FAIL reset_stall: v=%b A=%h d=%h need 0",
               out_valid, A, DestOut);
    end
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_capture();
    test_forward();
    test_imm();
    test_stall();
    test_flush();
    test_back_to_back();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
